// File: rtl/rx_sclk_pll_ctrl.sv
// ============================================================================
// rx_sclk_pll_ctrl
// ----------------------------------------------------------------------------
// Lock / reset / phase manager for the Gowin rPLL that produces the RX serial
// clock. Runs on the free-running reference clock beside the rPLL instance.
//
// Sequence: hold the PLL in reset, wait for LOCK, require LOCK to stay
// continuously high for a stability window, then release the RX-domain reset.
// A lock timeout causes a retry. After MAX_RETRY failed attempts the block
// parks in a terminal failure state until reset. While locked, a rising edge
// on ps_req steps PSDA by +/-1 (mod 16). ps_ack pulses once after the clock
// has had time to settle.
//
// Optional feature (macro RX_SCLK_LOSS_CNT_EN):
//   defined   - loss_cnt counts lock-loss events seen while locked or while
//               phase shifting, saturating at all-ones.
//   undefined - no counter logic; loss_cnt is tied to 0.
//
// Ports:
//   clkin        in   reference clock (free-running)
//   reset        in   asynchronous active-high reset
//   pll_lock     in   raw rPLL LOCK (asynchronous to clkin)
//   pll_reset    out  rPLL RESET
//   pll_reset_p  out  rPLL RESET_P
//   pll_psda     out  rPLL PSDA[3:0]
//   ps_req       in   phase-step request (rising edge accepted when locked)
//   ps_dir       in   phase-step direction, 1 = +1, 0 = -1
//   ps_ack       out  one-cycle phase-step completion pulse
//   pll_ready    out  PLL locked and stable
//   rx_rst       out  RX-domain reset, active-high
//   pll_fail     out  lock retries exhausted
//   loss_cnt     out  saturating lock-loss event count
// ============================================================================
module rx_sclk_pll_ctrl #(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 4096,
  parameter int         STABLE_CYCLES = 256,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         MAX_RETRY     = 3,
  parameter int         CNT_W         = 8,
  parameter logic [3:0] PSDA_INIT     = 4'b0000
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             pll_reset_p,
  output logic [3:0]       pll_psda,
  input  logic             ps_req,
  input  logic             ps_dir,
  output logic             ps_ack,
  output logic             pll_ready,
  output logic             rx_rst,
  output logic             pll_fail,
  output logic [CNT_W-1:0] loss_cnt
);

  // One shared timer serves every timed state, so it is sized for the longest.
  localparam int T_A     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_B     = (STABLE_CYCLES > SETTLE_CYCLES) ? STABLE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_LOCKED = 3'd3,
    S_PSHIFT = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t             state_q, state_nx;
  logic [TMR_W-1:0]   timer_q, timer_nx;
  logic [RTY_W-1:0]   retry_q, retry_nx;
  logic [3:0]         psda_nx;
  logic               ack_nx;
  logic               lock_p0, lock_s;
  logic               ps_req_d;
  logic               req_edge;
  logic               prst_nx, ready_nx, fail_nx;

  assign req_edge = ps_req & ~ps_req_d;

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    timer_nx = timer_q + TMR_W'(1);
    retry_nx = retry_q;
    psda_nx  = pll_psda;
    ack_nx   = 1'b0;
    case (state_q)
      S_RST: begin
        if (timer_q == TMR_W'(RST_CYCLES - 1)) begin
          state_nx = S_WAIT;
          timer_nx = '0;
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_nx = S_STABLE;
          timer_nx = '0;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          retry_nx = retry_q + RTY_W'(1);
          timer_nx = '0;
          state_nx = (retry_nx == RTY_W'(MAX_RETRY)) ? S_FAIL : S_RST;
        end
      end
      S_STABLE: begin
        // Any dropout restarts the lock wait with a fresh timeout; the retry
        // count is only cleared once the stability window is completed.
        if (!lock_s) begin
          state_nx = S_WAIT;
          timer_nx = '0;
        end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
          state_nx = S_LOCKED;
          timer_nx = '0;
          retry_nx = '0;
        end
      end
      S_LOCKED: begin
        // Lock loss has priority; a simultaneous request is dropped.
        timer_nx = '0;
        if (!lock_s) begin
          state_nx = S_RST;
        end else if (req_edge) begin
          psda_nx  = ps_dir ? (pll_psda + 4'd1) : (pll_psda - 4'd1);
          state_nx = S_PSHIFT;
        end
      end
      S_PSHIFT: begin
        // On lock loss the new PSDA value is kept and no ack is issued.
        if (!lock_s) begin
          state_nx = S_RST;
          timer_nx = '0;
        end else if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          state_nx = S_LOCKED;
          timer_nx = '0;
          ack_nx   = 1'b1;
        end
      end
      S_FAIL: begin
        timer_nx = '0;
      end
      default: begin
        state_nx = S_RST;
        timer_nx = '0;
      end
    endcase
  end

  // Output decode from the next state so that every output is a register
  // that is valid in the same cycle the state becomes current.
  always_comb begin
    prst_nx  = (state_nx == S_RST) || (state_nx == S_FAIL);
    ready_nx = (state_nx == S_LOCKED) || (state_nx == S_PSHIFT);
    fail_nx  = (state_nx == S_FAIL);
  end

  // State and output registers; lock synchroniser stage p0 -> lock_s
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= S_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      lock_p0     <= 1'b0;
      lock_s      <= 1'b0;
      ps_req_d    <= 1'b0;
      pll_reset   <= 1'b1;
      pll_reset_p <= 1'b1;
      pll_psda    <= PSDA_INIT;
      ps_ack      <= 1'b0;
      pll_ready   <= 1'b0;
      rx_rst      <= 1'b1;
      pll_fail    <= 1'b0;
    end else begin
      state_q     <= state_nx;
      timer_q     <= timer_nx;
      retry_q     <= retry_nx;
      lock_p0     <= pll_lock;
      lock_s      <= lock_p0;
      ps_req_d    <= ps_req;
      pll_reset   <= prst_nx;
      pll_reset_p <= prst_nx;
      pll_psda    <= psda_nx;
      ps_ack      <= ack_nx;
      pll_ready   <= ready_nx;
      rx_rst      <= ~ready_nx;
      pll_fail    <= fail_nx;
    end
  end

`ifdef RX_SCLK_LOSS_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_W'(1));
  endfunction

  logic loss_evt;
  assign loss_evt = ((state_q == S_LOCKED) || (state_q == S_PSHIFT)) && !lock_s;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      loss_cnt <= '0;
    end else if (loss_evt) begin
      loss_cnt <= sat_inc(loss_cnt);
    end
  end
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_sclk_pll_ctrl.sv
// ============================================================================
// tb_rx_sclk_pll_ctrl
// ----------------------------------------------------------------------------
// Directed bench for rx_sclk_pll_ctrl. A phase/countdown reference model
// predicts every output each cycle; a set of hand-computed cycle counts and
// values pins the model. Inputs change 2 time units after the rising edge;
// outputs are compared on the falling edge.
// ============================================================================
module tb_rx_sclk_pll_ctrl;

  localparam int         RST_CYCLES    = 16;
  localparam int         LOCK_TIMEOUT  = 4096;
  localparam int         STABLE_CYCLES = 256;
  localparam int         SETTLE_CYCLES = 64;
  localparam int         MAX_RETRY     = 3;
  localparam int         CNT_W         = 8;
  localparam logic [3:0] PSDA_INIT     = 4'b0000;
`ifdef RX_SCLK_LOSS_CNT_EN
  localparam int EXP_LOSS1 = 1;
`else
  localparam int EXP_LOSS1 = 0;
`endif

  logic             clkin = 1'b0;
  logic             reset;
  logic             pll_lock = 1'b0;
  logic             ps_req = 1'b0;
  logic             ps_dir = 1'b0;
  logic             pll_reset, pll_reset_p, ps_ack, pll_ready, rx_rst, pll_fail;
  logic [3:0]       pll_psda;
  logic [CNT_W-1:0] loss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clkin = ~clkin;

  rx_sclk_pll_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W), .PSDA_INIT(PSDA_INIT)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .pll_reset_p(pll_reset_p), .pll_psda(pll_psda),
    .ps_req(ps_req), .ps_dir(ps_dir), .ps_ack(ps_ack),
    .pll_ready(pll_ready), .rx_rst(rx_rst), .pll_fail(pll_fail),
    .loss_cnt(loss_cnt)
  );

  // --------------------------------------------------------------------------
  // Reference model: a phase with a countdown of remaining cycles.
  // --------------------------------------------------------------------------
  typedef enum int {P_HOLD, P_SEEK, P_SETTLE, P_RUN, P_STEP, P_DEAD} phase_t;
  phase_t     ph;
  int         left, tries, m_loss;
  logic [1:0] hist;
  logic       req_prev, m_ack, ls;
  logic [3:0] m_psda;

  always @(posedge clkin or posedge reset) begin
    if (reset) begin
      ph = P_HOLD; left = RST_CYCLES; tries = 0; m_loss = 0;
      hist = 2'b00; req_prev = 1'b0; m_ack = 1'b0; m_psda = PSDA_INIT;
    end else begin
      ls    = hist[1];
      m_ack = 1'b0;
      case (ph)
        P_HOLD: begin
          left--;
          if (left == 0) begin ph = P_SEEK; left = LOCK_TIMEOUT; end
        end
        P_SEEK: begin
          if (ls) begin
            ph = P_SETTLE; left = STABLE_CYCLES;
          end else begin
            left--;
            if (left == 0) begin
              tries++;
              if (tries == MAX_RETRY) ph = P_DEAD;
              else begin ph = P_HOLD; left = RST_CYCLES; end
            end
          end
        end
        P_SETTLE: begin
          if (!ls) begin
            ph = P_SEEK; left = LOCK_TIMEOUT;
          end else begin
            left--;
            if (left == 0) begin ph = P_RUN; tries = 0; end
          end
        end
        P_RUN, P_STEP: begin
          if (!ls) begin
`ifdef RX_SCLK_LOSS_CNT_EN
            if (m_loss < (1 << CNT_W) - 1) m_loss++;
`endif
            ph = P_HOLD; left = RST_CYCLES;
          end else if (ph == P_RUN) begin
            if (ps_req && !req_prev) begin
              m_psda = ps_dir ? m_psda + 4'd1 : m_psda - 4'd1;
              ph = P_STEP; left = SETTLE_CYCLES;
            end
          end else begin
            left--;
            if (left == 0) begin m_ack = 1'b1; ph = P_RUN; end
          end
        end
        default: ;
      endcase
      hist     = {hist[0], pll_lock};
      req_prev = ps_req;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges, landing 2 units after the last one.
  task automatic tick(input int n);
    repeat (n) begin @(posedge clkin); #2; end
  endtask

  // Count rising edges until the selected output reaches val; -1 on timeout.
  // sel: 0 pll_reset, 1 pll_ready, 2 ps_ack, 3 pll_fail
  task automatic edges_until(input int sel, input logic val, input int limit, output int n);
    logic s;
    bit   hit;
    n = 0; hit = 0;
    while (!hit && n < limit) begin
      @(posedge clkin); #1;
      n++;
      case (sel)
        0: s = pll_reset;
        1: s = pll_ready;
        2: s = ps_ack;
        default: s = pll_fail;
      endcase
      if (s == val) hit = 1;
    end
    if (!hit) n = -1;
    #1;
  endtask

  int n, acks;

  initial begin
    reset = 1'b1;
    fork
      forever begin
        @(negedge clkin);
        check("pll_reset",   pll_reset,   (ph == P_HOLD || ph == P_DEAD));
        check("pll_reset_p", pll_reset_p, (ph == P_HOLD || ph == P_DEAD));
        check("pll_ready",   pll_ready,   (ph == P_RUN || ph == P_STEP));
        check("rx_rst",      rx_rst,      !(ph == P_RUN || ph == P_STEP));
        check("pll_fail",    pll_fail,    (ph == P_DEAD));
        check("ps_ack",      ps_ack,      m_ack);
        check("pll_psda",    pll_psda,    m_psda);
        check("loss_cnt",    loss_cnt,    m_loss);
      end
    join_none

    // Reset values
    tick(3);
    check("rst_pll_reset", pll_reset, 1);
    check("rst_rx_rst",    rx_rst,    1);
    check("rst_ready",     pll_ready, 0);
    check("rst_psda",      pll_psda,  PSDA_INIT);

    // Power-up lock: reset pulse is 16 cycles, ready 259 edges after lock edge
    reset = 1'b0;
    edges_until(0, 1'b0, 100, n);
    check("rst_pulse_edges", n, 16);
    tick(84);
    pll_lock = 1'b1;
    edges_until(1, 1'b1, 1000, n);
    check("lock_to_ready", n, 259);
    check("rx_rst_released", rx_rst, 0);

    // Lock loss while locked: ready drops in 3 edges, then full re-lock
    pll_lock = 1'b0;
    edges_until(1, 1'b0, 50, n);
    check("loss_to_unready", n, 3);
    check("loss_rx_rst", rx_rst, 1);
    check("loss_cnt_val", loss_cnt, EXP_LOSS1);
    tick(2);
    pll_lock = 1'b1;
    edges_until(1, 1'b1, 1000, n);
    check("relock_edges", n, 271);

    // Phase steps: 0 -1 -> 15, held request gives no second step, 15 +1 -> 0
    ps_dir = 1'b0;
    ps_req = 1'b1;
    edges_until(2, 1'b1, 200, n);
    check("step_dn_ack_edges", n, 65);
    check("step_dn_psda", pll_psda, 15);
    ps_dir = 1'b1;
    acks = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clkin); #1;
      if (ps_ack) acks++;
      #1;
    end
    check("held_req_acks", acks, 0);
    check("held_req_psda", pll_psda, 15);
    ps_req = 1'b0;
    tick(2);
    ps_req = 1'b1;
    edges_until(2, 1'b1, 200, n);
    check("step_up_ack_edges", n, 65);
    check("step_up_psda", pll_psda, 0);
    ps_req = 1'b0;

    // Reset in the middle of a phase step
    tick(2);
    ps_req = 1'b1;
    tick(10);
    check("mid_step_psda", pll_psda, 1);
    reset = 1'b1;
    #1;
    check("midrst_pll_reset", pll_reset, 1);
    check("midrst_ready", pll_ready, 0);
    check("midrst_rx_rst", rx_rst, 1);
    check("midrst_psda", pll_psda, PSDA_INIT);
    check("midrst_ack", ps_ack, 0);
    check("midrst_loss", loss_cnt, 0);
    tick(3);
    ps_req = 1'b0;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clkin); #1;
      if (ps_ack) acks++;
      #1;
    end
    check("midrst_no_ack", acks, 0);

    // Lock dropout for 3 cycles at stable count 200
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(217);
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    edges_until(1, 1'b1, 1000, n);
    check("dropout_ready_edges", n, 259);

    // No lock at all: three attempts then terminal failure
    reset = 1'b1;
    pll_lock = 1'b0;
    tick(3);
    reset = 1'b0;
    edges_until(3, 1'b1, 13000, n);
    check("fail_edges", n, 3 * (RST_CYCLES + LOCK_TIMEOUT));
    check("fail_pll_reset", pll_reset, 1);
    pll_lock = 1'b1;
    tick(400);
    check("fail_sticky", pll_fail, 1);
    check("fail_no_ready", pll_ready, 0);
    check("fail_rst_held", pll_reset_p, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
